instr_fetch: RTL

- Fetch stage feeding the decode/control path. Holds the PC and issues in-order word requests to instruction memory over a valid/ready handshake.
- Buffers returned words with their PCs in a small FIFO and presents {inst, inst_pc} to decode over a valid/ready handshake.
- Consumes the branch decision (pc_sel plus target) from the control path to redirect fetch, flush the buffer, and discard stale in-flight responses.

---
 rtl/instr_fetch_pkg.sv | 13 +
 rtl/instr_fetch_if.sv | 22 ++
 rtl/instr_fetch_fifo.sv | 49 ++++
 rtl/instr_fetch.sv | 60 ++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared constants, state encoding and buffer entry type for the fetch stage
package instr_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {S_RESET, S_RUN, S_DRAIN} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory request/response and decode handshake bundle
interface instr_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
endinterface

// File: rtl/instr_fetch_fifo.sv
// instr_fetch_fifo: flushable FIFO of fetched {pc, inst} entries
module instr_fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);
  localparam int PW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    do_pop = pop && count != '0;
    head = mem[rd];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= nxt(wr);
      end
      if (do_pop) rd <= nxt(rd);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (!rst && !flush && push && !do_pop) assert (count != CW'(DEPTH));
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC/request generator with response buffer, credit flow control and branch redirect
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] branch_target,
  instr_fetch_if.master   bus
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  fetch_state_t state;
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0] outstanding, drop_cnt, drop_nxt, fifo_count;
  logic req_fire, rsp_live, pop;
  fetch_entry_t entry, head;
  instr_fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (rsp_live),
    .pop   (pop),
    .flush (pc_sel),
    .din   (entry),
    .count (fifo_count),
    .head  (head)
  );
  always_comb begin
    bus.imem_req_valid = state != S_RESET && !pc_sel &&
                         ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(BUF_DEPTH);
    bus.imem_req_addr = fetch_pc;
    req_fire = bus.imem_req_valid && bus.imem_req_ready;
    rsp_live = bus.imem_rsp_valid && drop_cnt == '0 && !pc_sel;
    entry = '{pc: rsp_pc, inst: bus.imem_rsp_data};
    drop_nxt = pc_sel ? outstanding - CW'(bus.imem_rsp_valid)
                      : drop_cnt - CW'(bus.imem_rsp_valid && drop_cnt != '0);
    bus.inst_valid = fifo_count != '0;
    pop = bus.inst_valid && bus.inst_ready;
    bus.inst = head.inst;
    bus.inst_pc = head.pc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state == S_RESET ? S_RUN : drop_nxt != '0 ? S_DRAIN : S_RUN;
      outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      drop_cnt <= drop_nxt;
      fetch_pc <= pc_sel ? word_align(branch_target) : fetch_pc + (req_fire ? XLEN'(4) : '0);
      rsp_pc <= pc_sel ? word_align(branch_target) : rsp_pc + (rsp_live ? XLEN'(4) : '0);
    end
  end
endmodule
